// File: rtl/demux_pkg.sv
// Shared helpers for the stream demux: select-width sizing, mode encoding and the saturating drop counter step.
package demux_pkg;

    localparam logic MODE_UNICAST = 1'b0;
    localparam logic MODE_BCAST   = 1'b1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Next value of a w-bit counter that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] drop_sat(input logic [31:0] cnt, input int w);
        logic [31:0] top;
        top = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (cnt >= top) ? top : cnt + 32'd1;
    endfunction

endpackage

// File: rtl/demux_out_slot.sv
// One-entry valid/ready output register: a loaded beat is visible the edge after load.
// Holds its beat while the consumer stalls; free means it can take a beat at this edge.
module demux_out_slot #(
    parameter int DATA_W = 8
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] d,
    output logic              o_valid,
    input  logic              o_ready,
    output logic [DATA_W-1:0] q,
    output logic              free
);

    assign free = ~o_valid | o_ready;

    // Load wins over drain so a draining slot can refill on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_valid <= 1'b0;
            q       <= '0;
        end else if (load) begin
            o_valid <= 1'b1;
            q       <= d;
        end else if (o_ready) begin
            o_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_stream_n.sv
// 1-to-N stream demux with broadcast; each beat lands in a per-channel register one edge after acceptance.
// in_ready follows the addressed slot (all slots on broadcast); out-of-range selects are accepted and dropped.
module demux_stream_n
    import demux_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int N_OUT  = 4,
    parameter int SEL_W  = clog2(N_OUT),
    parameter int CNT_W  = 8
)(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_bcast,
    output logic [N_OUT-1:0]        out_valid,
    input  logic [N_OUT-1:0]        out_ready,
    output logic [N_OUT*DATA_W-1:0] out_data,
    output logic                    err_drop,
    output logic [CNT_W-1:0]        drop_cnt
);

    localparam int SEL_N = 1 << SEL_W;

    logic [N_OUT-1:0] free;
    logic [N_OUT-1:0] load;
    logic [SEL_N-1:0] free_pad;
    logic             sel_ok;
    logic             rdy_raw;
    logic             fire;
    logic             drop;

    // Padding lets every encodable select index the free vector safely.
    assign free_pad = SEL_N'(free);
    assign sel_ok   = (32'(in_sel) < N_OUT);

    always_comb begin
        rdy_raw = 1'b0;
        if (in_bcast == MODE_BCAST)
            rdy_raw = &free;
        else if (!sel_ok)
            rdy_raw = 1'b1;
        else
            rdy_raw = free_pad[in_sel];
    end

    assign in_ready = rst_n & rdy_raw;
    assign fire     = in_valid & in_ready;
    assign drop     = fire & (in_bcast == MODE_UNICAST) & ~sel_ok;

    always_comb begin
        load = '0;
        for (int i = 0; i < N_OUT; i++)
            load[i] = fire & ((in_bcast == MODE_BCAST) | (32'(in_sel) == i));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_drop <= 1'b0;
            drop_cnt <= '0;
        end else begin
            err_drop <= drop;
            if (drop)
                drop_cnt <= CNT_W'(drop_sat(32'(drop_cnt), CNT_W));
        end
    end

    for (genvar g = 0; g < N_OUT; g++) begin : g_slot
        demux_out_slot #(.DATA_W(DATA_W)) u_slot (
            .clk     (clk),
            .rst_n   (rst_n),
            .load    (load[g]),
            .d       (in_data),
            .o_valid (out_valid[g]),
            .o_ready (out_ready[g]),
            .q       (out_data[g*DATA_W +: DATA_W]),
            .free    (free[g])
        );
    end

endmodule

// File: tb/tb_demux_stream_n.sv
// Bench for demux_stream_n: a 4-channel instance with a per-channel scoreboard and a 3-channel instance for bad selects.
module tb_demux_stream_n;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        in_valid4, in_ready4, in_bcast4, err_drop4;
    logic [7:0]  in_data4, drop_cnt4;
    logic [1:0]  in_sel4;
    logic [3:0]  out_valid4, out_ready4;
    logic [31:0] out_data4;

    logic        in_valid3, in_ready3, in_bcast3, err_drop3;
    logic [7:0]  in_data3, drop_cnt3;
    logic [1:0]  in_sel3;
    logic [2:0]  out_valid3, out_ready3;
    logic [23:0] out_data3;

    demux_stream_n #(.DATA_W(8), .N_OUT(4), .SEL_W(2), .CNT_W(8)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .in_data(in_data4), .in_sel(in_sel4), .in_bcast(in_bcast4),
        .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
        .err_drop(err_drop4), .drop_cnt(drop_cnt4)
    );

    demux_stream_n #(.DATA_W(8), .N_OUT(3), .SEL_W(2), .CNT_W(8)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3),
        .in_data(in_data3), .in_sel(in_sel3), .in_bcast(in_bcast3),
        .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
        .err_drop(err_drop3), .drop_cnt(drop_cnt3)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Per-channel scoreboard for dut4: pushed on input transfer, popped on output transfer.
    logic [7:0] sb_q[4][$];

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) sb_q[i].delete();
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (out_valid4[i] && out_ready4[i]) begin
                    if (sb_q[i].size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL sb_unexpected ch%0d: got beat %0h, expected none", i, out_data4[i*8 +: 8]);
                    end else begin
                        chk($sformatf("sb_data ch%0d", i), 32'(out_data4[i*8 +: 8]), 32'(sb_q[i].pop_front()));
                    end
                end
            end
            if (in_valid4 && in_ready4) begin
                for (int i = 0; i < 4; i++)
                    if (in_bcast4 || (int'(in_sel4) == i)) sb_q[i].push_back(in_data4);
            end
        end
    end

    typedef struct {
        logic       vld;
        logic [1:0] sel;
        logic       bc;
        logic [7:0] dat;
        logic [3:0] ordy;
        logic       exp_rdy;
        logic [3:0] exp_ov;
    } vec_t;

    vec_t vt[7];

    initial begin
        vt[0] = '{1'b1, 2'd0, 1'b0, 8'hA0, 4'hF, 1'b1, 4'h1};
        vt[1] = '{1'b1, 2'd1, 1'b0, 8'hA1, 4'hF, 1'b1, 4'h2};
        vt[2] = '{1'b1, 2'd2, 1'b0, 8'hA2, 4'hF, 1'b1, 4'h4};
        vt[3] = '{1'b1, 2'd3, 1'b0, 8'hA3, 4'hF, 1'b1, 4'h8};
        vt[4] = '{1'b0, 2'd0, 1'b0, 8'h00, 4'hF, 1'b1, 4'h0};
        vt[5] = '{1'b1, 2'd1, 1'b1, 8'h5A, 4'hF, 1'b1, 4'hF};
        vt[6] = '{1'b0, 2'd0, 1'b0, 8'h00, 4'hF, 1'b1, 4'h0};

        // T1: reset held with traffic offered on both instances
        rst_n = 1'b0;
        in_valid4 = 1'b1; in_sel4 = 2'd1; in_bcast4 = 1'b0; in_data4 = 8'hEE; out_ready4 = 4'hF;
        in_valid3 = 1'b1; in_sel3 = 2'd3; in_bcast3 = 1'b0; in_data3 = 8'hDD; out_ready3 = 3'h7;
        #1;
        chk("t1_in_ready4_pre", 32'(in_ready4), 32'd0);
        chk("t1_in_ready3_pre", 32'(in_ready3), 32'd0);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("t1_in_ready4", 32'(in_ready4), 32'd0);
            chk("t1_in_ready3", 32'(in_ready3), 32'd0);
            chk("t1_out_valid4", 32'(out_valid4), 32'd0);
            chk("t1_out_valid3", 32'(out_valid3), 32'd0);
            chk("t1_drop_cnt3", 32'(drop_cnt3), 32'd0);
            chk("t1_err_drop3", 32'(err_drop3), 32'd0);
            chk("t1_out_data4", out_data4, 32'd0);
        end
        rst_n = 1'b1;
        in_valid4 = 1'b0;
        in_valid3 = 1'b0;

        // T2: table of unicast sweep, idle and broadcast cycles
        for (int r = 0; r < 7; r++) begin
            in_valid4 = vt[r].vld; in_sel4 = vt[r].sel; in_bcast4 = vt[r].bc;
            in_data4 = vt[r].dat; out_ready4 = vt[r].ordy;
            #1;
            chk($sformatf("t2_in_ready row%0d", r), 32'(in_ready4), 32'(vt[r].exp_rdy));
            step();
            chk($sformatf("t2_out_valid row%0d", r), 32'(out_valid4), 32'(vt[r].exp_ov));
        end
        in_valid4 = 1'b0;
        chk("t2_drop_cnt4", 32'(drop_cnt4), 32'd0);

        // T3: stalled slot 2 holds 0x55 and blocks 0x66 until its consumer returns
        out_ready4 = 4'b1011;
        in_valid4 = 1'b1; in_sel4 = 2'd2; in_bcast4 = 1'b0; in_data4 = 8'h55;
        #1;
        chk("t3_ready_first", 32'(in_ready4), 32'd1);
        step();
        in_data4 = 8'h66;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("t3_ready_blocked", 32'(in_ready4), 32'd0);
            chk("t3_valid_held", 32'(out_valid4), 32'h4);
            chk("t3_data_held", 32'(out_data4[23:16]), 32'h55);
            step();
        end
        out_ready4 = 4'hF;
        #1;
        chk("t3_ready_drain", 32'(in_ready4), 32'd1);
        step();
        in_valid4 = 1'b0;
        chk("t3_valid_second", 32'(out_valid4), 32'h4);
        chk("t3_data_second", 32'(out_data4[23:16]), 32'h66);
        step();
        chk("t3_valid_empty", 32'(out_valid4), 32'h0);

        // T4: broadcast waits for the one busy slot, then loads all four at once
        out_ready4 = 4'b1011;
        in_valid4 = 1'b1; in_sel4 = 2'd2; in_bcast4 = 1'b0; in_data4 = 8'h11;
        step();
        in_bcast4 = 1'b1; in_sel4 = 2'd0; in_data4 = 8'h3C;
        for (int c = 0; c < 2; c++) begin
            #1;
            chk("t4_ready_blocked", 32'(in_ready4), 32'd0);
            step();
            chk("t4_valid_partial", 32'(out_valid4), 32'h4);
        end
        out_ready4 = 4'hF;
        #1;
        chk("t4_ready_open", 32'(in_ready4), 32'd1);
        step();
        in_valid4 = 1'b0; in_bcast4 = 1'b0;
        chk("t4_valid_all", 32'(out_valid4), 32'hF);
        chk("t4_data_all", out_data4, 32'h3C3C_3C3C);
        step();
        chk("t4_valid_empty", 32'(out_valid4), 32'h0);

        // T5: 300 beats to select 3 on the 3-channel instance
        in_valid3 = 1'b1; in_sel3 = 2'd3; in_bcast3 = 1'b0; out_ready3 = 3'h7;
        for (int k = 1; k <= 300; k++) begin
            in_data3 = 8'(k);
            #1;
            chk("t5_in_ready", 32'(in_ready3), 32'd1);
            step();
            chk("t5_err_drop", 32'(err_drop3), 32'd1);
            chk("t5_drop_cnt", 32'(drop_cnt3), (k > 255) ? 32'd255 : 32'(k));
            chk("t5_out_valid", 32'(out_valid3), 32'd0);
        end
        in_sel3 = 2'd1; in_data3 = 8'h99;
        step();
        in_valid3 = 1'b0;
        chk("t5_err_drop_good", 32'(err_drop3), 32'd0);
        chk("t5_drop_cnt_hold", 32'(drop_cnt3), 32'd255);
        chk("t5_good_valid", 32'(out_valid3), 32'h2);
        chk("t5_good_data", 32'(out_data3[15:8]), 32'h99);
        step();
        chk("t5_idle_err", 32'(err_drop3), 32'd0);
        chk("t5_idle_cnt", 32'(drop_cnt3), 32'd255);

        // T6: reset with every slot full and the drop counter saturated
        out_ready4 = 4'h0;
        in_valid4 = 1'b1; in_bcast4 = 1'b1; in_data4 = 8'h77;
        step();
        chk("t6_valid_full", 32'(out_valid4), 32'hF);
        rst_n = 1'b0;
        in_data4 = 8'h88;
        #1;
        chk("t6_ready_in_reset", 32'(in_ready4), 32'd0);
        step();
        rst_n = 1'b1;
        in_valid4 = 1'b0; in_bcast4 = 1'b0;
        out_ready4 = 4'hF;
        chk("t6_valid_cleared", 32'(out_valid4), 32'h0);
        chk("t6_drop_cnt_cleared", 32'(drop_cnt3), 32'd0);
        chk("t6_err_cleared", 32'(err_drop3), 32'd0);
        for (int c = 0; c < 4; c++) begin
            step();
            chk("t6_no_stale", 32'(out_valid4), 32'h0);
        end

        for (int i = 0; i < 4; i++)
            chk($sformatf("sb_left ch%0d", i), 32'(sb_q[i].size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog");
    end

endmodule
